reflex_gate_sample_feeder: RTL

Producer end of the reflex kernel gate input interface. Accepts raw phase and QSFS samples over a valid/ready stream, timestamps them with a local microsecond timer, and forms the dt_us / dphi_e4 / qsfs_e4 bundle. Pairs the bundle with a frame-coherent packed_const word and presents it as a registered, backpressured output stream. Its outputs feed reflex_kernel_gate and gate_golden in parallel.

---
 rtl/reflex_gate_sample_feeder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/reflex_gate_sample_feeder.sv
// Producer side of the reflex kernel gate input: timestamps phase/QSFS samples and emits a
// registered dt_us/dphi_e4/qsfs_e4 bundle with a frame-coherent constant. Optional REFLEX_FEED_STATS_EN adds frame/saturation counters.
module reflex_gate_sample_feeder #(
    parameter int CONST_W      = 64,
    parameter int DT_W         = 32,
    parameter int DPHI_W       = 16,
    parameter int QSFS_W       = 16,
    parameter int TICKS_PER_US = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CONST_W-1:0] cfg_wdata,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DPHI_W-1:0]  s_phase_e4,
    input  logic [QSFS_W-1:0]  s_qsfs_e4,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [CONST_W-1:0] packed_const,
    output logic [DT_W-1:0]    dt_us,
    output logic [DPHI_W-1:0]  dphi_e4,
    output logic [QSFS_W-1:0]  qsfs_e4
`ifdef REFLEX_FEED_STATS_EN
    ,
    output logic [31:0]        frame_cnt,
    output logic [15:0]        sat_cnt
`endif
);

    localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICKS_PER_US - 1);
    localparam logic [DT_W-1:0]   DT_MAX   = {DT_W{1'b1}};
    localparam logic [DPHI_W-1:0] DPHI_MIN = {1'b1, {(DPHI_W-1){1'b0}}};
    localparam logic [DPHI_W-1:0] DPHI_MAX = {1'b0, {(DPHI_W-1){1'b1}}};

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Magnitude of the wrapped phase step; the most negative step clamps to the largest positive value.
    function automatic logic [DPHI_W-1:0] phase_step_mag(input logic [DPHI_W-1:0] cur,
                                                         input logic [DPHI_W-1:0] prev);
        logic [DPHI_W-1:0] diff;
        diff = cur - prev;
        if (diff == DPHI_MIN) begin
            return DPHI_MAX;
        end else if (diff[DPHI_W-1]) begin
            return (~diff) + {{(DPHI_W-1){1'b0}}, 1'b1};
        end else begin
            return diff;
        end
    endfunction

    function automatic logic phase_step_sat(input logic [DPHI_W-1:0] cur,
                                            input logic [DPHI_W-1:0] prev);
        logic [DPHI_W-1:0] diff;
        diff = cur - prev;
        return (diff == DPHI_MIN);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_s_ready;
    logic                w_accept;
    logic                w_emit;
    logic                w_load;
    logic                w_tick;
    logic [PRE_W-1:0]    r_presc;
    logic [PRE_W-1:0]    w_presc_nxt;
    logic [DT_W-1:0]     r_us_ctr;
    logic [DT_W-1:0]     w_us_ctr_nxt;
    logic [CONST_W-1:0]  r_shadow;
    logic [DPHI_W-1:0]   r_prev_phase;
    logic                r_m_valid;
    logic [CONST_W-1:0]  r_const;
    logic [DT_W-1:0]     r_dt;
    logic [DPHI_W-1:0]   r_dphi;
    logic [QSFS_W-1:0]   r_qsfs;

    assign w_accept = s_valid & w_s_ready;
    assign w_emit   = r_m_valid & m_ready;
    assign w_load   = w_accept & (r_state == ST_RUN);
    assign w_tick   = (r_presc == PRE_LAST);

    assign s_ready      = w_s_ready;
    assign m_valid      = r_m_valid;
    assign packed_const = r_const;
    assign dt_us        = r_dt;
    assign dphi_e4      = r_dphi;
    assign qsfs_e4      = r_qsfs;

    // Handshake readiness and next state; the output register is one deep, so RUN refills on emit.
    always_comb begin
        w_s_ready   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_PRIME: begin
                w_s_ready = 1'b1;
                if (s_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PRIME;
                end
            end
            ST_RUN: begin
                w_s_ready   = (~r_m_valid) | m_ready;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_s_ready   = 1'b0;
                w_state_nxt = ST_PRIME;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Microsecond timer next values: an accept clears it and wins over a coincident tick.
    always_comb begin
        w_presc_nxt  = r_presc;
        w_us_ctr_nxt = r_us_ctr;
        if (w_accept) begin
            w_presc_nxt  = {PRE_W{1'b0}};
            w_us_ctr_nxt = {DT_W{1'b0}};
        end else if (w_tick) begin
            w_presc_nxt = {PRE_W{1'b0}};
            if (r_us_ctr != DT_MAX) begin
                w_us_ctr_nxt = r_us_ctr + {{(DT_W-1){1'b0}}, 1'b1};
            end else begin
                w_us_ctr_nxt = r_us_ctr;
            end
        end else begin
            w_presc_nxt  = r_presc + PRE_W'(1);
            w_us_ctr_nxt = r_us_ctr;
        end
    end

    // Timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= {PRE_W{1'b0}};
            r_us_ctr <= {DT_W{1'b0}};
        end else begin
            r_presc  <= w_presc_nxt;
            r_us_ctr <= w_us_ctr_nxt;
        end
    end

    // Shadow constant and last accepted phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= {CONST_W{1'b0}};
            r_prev_phase <= {DPHI_W{1'b0}};
        end else begin
            if (cfg_we) begin
                r_shadow <= cfg_wdata;
            end else begin
                r_shadow <= r_shadow;
            end
            if (w_accept) begin
                r_prev_phase <= s_phase_e4;
            end else begin
                r_prev_phase <= r_prev_phase;
            end
        end
    end

    // Output bundle register; the constant is captured only here so it cannot change mid-hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_const   <= {CONST_W{1'b0}};
            r_dt      <= {DT_W{1'b0}};
            r_dphi    <= {DPHI_W{1'b0}};
            r_qsfs    <= {QSFS_W{1'b0}};
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_const   <= cfg_we ? cfg_wdata : r_shadow;
            r_dt      <= r_us_ctr;
            r_dphi    <= phase_step_mag(s_phase_e4, r_prev_phase);
            r_qsfs    <= s_qsfs_e4;
        end else if (w_emit) begin
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= r_m_valid;
        end
    end

`ifdef REFLEX_FEED_STATS_EN
    logic [31:0] r_frame_cnt;
    logic [15:0] r_sat_cnt;
    logic        w_sat_evt;

    assign w_sat_evt = w_load & ((r_us_ctr == DT_MAX) | phase_step_sat(s_phase_e4, r_prev_phase));
    assign frame_cnt = r_frame_cnt;
    assign sat_cnt   = r_sat_cnt;

    // Frame counter wraps; saturation counter sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 32'd0;
            r_sat_cnt   <= 16'd0;
        end else begin
            if (w_emit) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
            if (w_sat_evt && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end else begin
                r_sat_cnt <= r_sat_cnt;
            end
        end
    end
`endif

endmodule
